// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake for uart_tx_cfg: producer pushes words, transmitter reports FIFO space.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with input FIFO; frames go out LSB-first, back-to-back,
// with optional odd/even parity and one or two stop bits.
module uart_tx_cfg #(
    parameter int unsigned CLK_PER_BIT = 10416,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    uart_tx_cfg_if.slave                       bus,
    output logic                               tx_o,
    output logic                               tx_busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned ClkW   = $clog2(CLK_PER_BIT);
    localparam int unsigned BitW   = $clog2(DATA_BITS);

    localparam logic [ClkW-1:0]   ClkLast  = ClkW'(CLK_PER_BIT - 1);
    localparam logic [BitW-1:0]   DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]   StopLast = BitW'(STOP_BITS - 1);
    localparam logic [CountW-1:0] Full     = CountW'(FIFO_DEPTH);
    localparam logic              OddPar   = (PARITY == 1);
    localparam logic              HasPar   = (PARITY != 0);

    if (PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal PARITY or STOP_BITS parameter");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]    count_q, count_d;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 par_load;

    // Serialiser
    state_e               state_q, state_d;
    logic [ClkW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    // Ready comes from the registered count only, so a pop on a full FIFO cannot admit a write
    // on the same edge.
    assign bus.tx_ready = (count_q != Full);
    assign push         = bus.tx_start && bus.tx_ready;
    assign fifo_empty   = (count_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign par_load     = (^head) ^ OddPar;
    assign bit_end      = (clk_cnt_q == ClkLast);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        if (state_q != StIdle) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + ClkW'(1);
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    par_d     = par_load;
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == DataLast) begin
                        bit_cnt_d = '0;
                        if (HasPar) begin
                            tx_d    = par_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_cnt_q == StopLast) begin
                        bit_cnt_d = '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = par_load;
                            tx_d    = 1'b0;
                            state_d = StStart;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_o         = tx_q;
    assign tx_busy_o    = (state_q != StIdle) || !fifo_empty;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: five instances cover 8N1, 7O2, 7E2, 5N1 and 9N1 framing.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic [4:0] start_v;
    logic [8:0] data_v;
    logic [4:0] tx_w;
    logic [4:0] busy_w;
    logic [4:0] ready_w;
    logic [2:0] cnt_w [5];

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_b ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_c ();
    uart_tx_cfg_if #(.DATA_BITS(5)) if_d ();
    uart_tx_cfg_if #(.DATA_BITS(9)) if_e ();

    assign if_a.tx_start = start_v[0];
    assign if_b.tx_start = start_v[1];
    assign if_c.tx_start = start_v[2];
    assign if_d.tx_start = start_v[3];
    assign if_e.tx_start = start_v[4];
    assign if_a.tx_data  = data_v[7:0];
    assign if_b.tx_data  = data_v[6:0];
    assign if_c.tx_data  = data_v[6:0];
    assign if_d.tx_data  = data_v[4:0];
    assign if_e.tx_data  = data_v[8:0];
    assign ready_w = {if_e.tx_ready, if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .bus(if_a), .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]),
        .fifo_count_o(cnt_w[0]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .bus(if_b), .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]),
        .fifo_count_o(cnt_w[1]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .bus(if_c), .tx_o(tx_w[2]), .tx_busy_o(busy_w[2]),
        .fifo_count_o(cnt_w[2]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(rst), .bus(if_d), .tx_o(tx_w[3]), .tx_busy_o(busy_w[3]),
        .fifo_count_o(cnt_w[3]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst(rst), .bus(if_e), .tx_o(tx_w[4]), .tx_busy_o(busy_w[4]),
        .fifo_count_o(cnt_w[4]));

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input int idx, input logic [8:0] d);
        start_v[idx] = 1'b1;
        data_v       = d;
        tick(1);
        start_v[idx] = 1'b0;
    endtask

    task automatic wait_fall(input int idx, input int budget, input string name);
        int n = 0;
        while (tx_w[idx] !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (tx_w[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: tx=%b after %0d cycles, want 0", name, tx_w[idx], budget);
        end
    endtask

    // Entered 1 unit after the edge that starts bit 'first'; returns 1 unit after the frame ends.
    task automatic check_frame(input int idx, input logic [15:0] bits, input int nbits,
                               input int first, input string name);
        for (int k = first; k < nbits; k++) begin
            tick((k == first) ? 2 : 4);
            n_cmp++;
            if (tx_w[idx] !== bits[k]) begin
                n_fail++;
                $display("FAIL %s bit %0d: tx=%b, want %b", name, k, tx_w[idx], bits[k]);
            end
            n_cmp++;
            if (busy_w[idx] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy bit %0d: busy=%b, want 1", name, k, busy_w[idx]);
            end
        end
        tick(2);
    endtask

    task automatic check_idle(input int idx, input string name);
        n_cmp++;
        if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0 || ready_w[idx] !== 1'b1 ||
            cnt_w[idx] !== 3'd0) begin
            n_fail++;
            $display("FAIL %s idle: tx=%b busy=%b ready=%b count=%0d, want 1 0 1 0", name,
                     tx_w[idx], busy_w[idx], ready_w[idx], cnt_w[idx]);
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        start_v = '0;
        data_v  = '0;
        #3;
        for (int i = 0; i < 5; i++) check_idle(i, "reset");
        tick(2);
        rst = 1'b0;
        tick(1);
        check_idle(0, "post_reset");
    endtask

    task automatic test_baseline;
        int n;
        write(0, 9'h0A5);
        n_cmp++;
        if (cnt_w[0] !== 3'd1 || busy_w[0] !== 1'b1 || tx_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL base accept: count=%0d busy=%b tx=%b, want 1 1 1",
                     cnt_w[0], busy_w[0], tx_w[0]);
        end
        tick(1);
        n_cmp++;
        if (cnt_w[0] !== 3'd0 || tx_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL base pop: count=%0d tx=%b, want 0 0", cnt_w[0], tx_w[0]);
        end
        check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, 0, "base");
        check_idle(0, "base_end");
        // Second frame measures busy length: acceptance cycle plus 10 bits of 4 clocks.
        write(0, 9'h0A5);
        n = 0;
        while (busy_w[0] === 1'b1 && n < 100) begin
            n++;
            tick(1);
        end
        n_cmp++;
        if (n != 41) begin
            n_fail++;
            $display("FAIL base busy_len: busy for %0d cycles, want 41", n);
        end
    endtask

    task automatic test_parity;
        write(1, 9'h003);
        wait_fall(1, 4, "odd");
        check_frame(1, {2'b11, 1'b1, 7'h03, 1'b0}, 11, 0, "odd");
        check_idle(1, "odd_end");
        write(2, 9'h003);
        wait_fall(2, 4, "even");
        check_frame(2, {2'b11, 1'b0, 7'h03, 1'b0}, 11, 0, "even");
        check_idle(2, "even_end");
    endtask

    task automatic test_fifo_backpressure;
        logic [7:0] w [6];
        logic [2:0] exp_cnt [6];
        w       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int i = 0; i < 6; i++) begin
            start_v[0] = 1'b1;
            data_v     = {1'b0, w[i]};
            n_cmp++;
            if (ready_w[0] !== (i < 5)) begin
                n_fail++;
                $display("FAIL fifo ready[%0d]: ready=%b, want %b", i, ready_w[0], (i < 5));
            end
            tick(1);
            n_cmp++;
            if (cnt_w[0] !== exp_cnt[i]) begin
                n_fail++;
                $display("FAIL fifo count[%0d]: count=%0d, want %0d", i, cnt_w[0], exp_cnt[i]);
            end
            if (i == 1) begin
                n_cmp++;
                if (tx_w[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fifo first_start: tx=%b, want 0", tx_w[0]);
                end
            end
        end
        start_v[0] = 1'b0;
        // First frame began at the second write edge, so bit 0 is already behind us.
        check_frame(0, {1'b1, w[0], 1'b0}, 10, 1, "fifo0");
        for (int f = 1; f < 5; f++) begin
            n_cmp++;
            if (tx_w[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL fifo gap%0d: tx=%b, want 0", f, tx_w[0]);
            end
            check_frame(0, {1'b1, w[f], 1'b0}, 10, 0, "fifo");
        end
        check_idle(0, "fifo_end");
    endtask

    task automatic test_simul_push_pop;
        write(0, 9'h081);
        write(0, 9'h07E);
        n_cmp++;
        if (cnt_w[0] !== 3'd1 || tx_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul idle_pop: count=%0d tx=%b, want 1 0", cnt_w[0], tx_w[0]);
        end
        check_frame(0, {1'b1, 8'h81, 1'b0}, 9, 0, "simul_a");
        tick(3);
        n_cmp++;
        if (cnt_w[0] !== 3'd1 || tx_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL simul pre: count=%0d tx=%b, want 1 1", cnt_w[0], tx_w[0]);
        end
        start_v[0] = 1'b1;
        data_v     = 9'h0C3;
        tick(1);
        start_v[0] = 1'b0;
        n_cmp++;
        if (cnt_w[0] !== 3'd1 || tx_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul stop_pop: count=%0d tx=%b, want 1 0", cnt_w[0], tx_w[0]);
        end
        check_frame(0, {1'b1, 8'h7E, 1'b0}, 10, 0, "simul_b");
        n_cmp++;
        if (tx_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul gap: tx=%b, want 0", tx_w[0]);
        end
        check_frame(0, {1'b1, 8'hC3, 1'b0}, 10, 0, "simul_c");
        check_idle(0, "simul_end");
    endtask

    task automatic test_reset_midframe;
        write(0, 9'h052);
        write(0, 9'h00F);
        write(0, 9'h0F0);
        n_cmp++;
        if (cnt_w[0] !== 3'd2) begin
            n_fail++;
            $display("FAIL rst queued: count=%0d, want 2", cnt_w[0]);
        end
        tick(16);
        n_cmp++;
        if (tx_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst bit3: tx=%b, want 0", tx_w[0]);
        end
        rst = 1'b1;
        #1;
        check_idle(0, "rst_async");
        tick(1);
        rst = 1'b0;
        tick(1);
        check_idle(0, "rst_release");
        write(0, 9'h03C);
        wait_fall(0, 4, "rst_fresh");
        check_frame(0, {1'b1, 8'h3C, 1'b0}, 10, 0, "rst_fresh");
        check_idle(0, "rst_fresh_end");
    endtask

    task automatic test_widths;
        write(3, 9'h01F);
        wait_fall(3, 4, "w5");
        check_frame(3, {1'b1, 5'h1F, 1'b0}, 7, 0, "w5");
        check_idle(3, "w5_end");
        tick(4);
        check_idle(3, "w5_quiet");
        write(4, 9'h155);
        wait_fall(4, 4, "w9");
        check_frame(4, {1'b1, 9'h155, 1'b0}, 11, 0, "w9");
        check_idle(4, "w9_end");
        tick(4);
        check_idle(4, "w9_quiet");
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_parity();
        test_fifo_backpressure();
        test_simul_push_pop();
        test_reset_midframe();
        test_widths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a small input FIFO. It serialises queued words LSB-first as a start bit, DATA_BITS data bits, an optional parity bit and 1 or 2 stop bits, each bit lasting CLK_PER_BIT clocks. Queued words go out back-to-back with no idle gap. It sits between the byte-producing logic and the serial pin, and replaces the fixed 8N1 transmitter in new designs.

## Interface
- CLK_PER_BIT, 10416: clocks per bit (9600 baud at 100 MHz); legal range ≥2.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.

- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tx_start, input, 1: write strobe; a word is accepted on an edge where tx_start=1 and tx_ready=1.
- tx_data, input, DATA_BITS: word to queue; sampled on acceptance.
- tx_ready, output, 1: FIFO not full.
- tx, output, 1: serial line; idles high; registered.
- tx_busy, output, 1: FSM not in IDLE, or FIFO not empty.
- fifo_count, output, $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty, pop the head into the shift register, set tx<=0 and go to START.
- START:
  - Hold tx=0 for CLK_PER_BIT cycles, then drive data bit 0 and go to DATA.
- DATA:
  - Shift out bits 0..DATA_BITS-1, each held CLK_PER_BIT cycles.
  - After the last bit, go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - Odd mode: the parity bit makes the total count of ones (data plus parity) odd.
  - Even mode: the parity bit makes that total even.
  - Computed from the popped word; held CLK_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS×CLK_PER_BIT cycles.
  - At the end: if the FIFO is non-empty, pop and go directly to START (tx<=0 on the same edge).
  - Otherwise go to IDLE.
- Frame length is 1+DATA_BITS+(PARITY≠0)+STOP_BITS bits.
- Bit counter and clock counter widths: $clog2 of their maximum values. No overflow is possible within legal parameter ranges.
- FIFO:
  - Write when tx_start && tx_ready.
  - Pop only at the FSM transitions above.
  - A write and a pop on the same edge leaves fifo_count unchanged.
  - When full, tx_ready=0, even if a pop happens on the same edge; the write is ignored.
  - tx_start while tx_ready=0 is dropped silently.
  - Pointers wrap modulo FIFO_DEPTH.
- PARITY=3 or STOP_BITS outside 1–2 is illegal. Behaviour is undefined; flag it in simulation with an initial check.

## Timing
- Reset values (asynchronous, immediate):
  - tx=1, tx_busy=0, tx_ready=1, fifo_count=0.
  - FSM=IDLE; counters=0; FIFO flushed.
- Reset mid-frame aborts the frame. tx returns high within the reset assertion, not at the next edge.
- Latency:
  - Word accepted at edge E0 into an empty FIFO with the FSM in IDLE.
  - fifo_count=1 after E0; the pop at E1 makes fifo_count=0.
  - tx falls after E1; tx_busy=1 from E0 through the end of the last stop bit.
- Each bit period is exactly CLK_PER_BIT cycles, measured edge to edge on tx.
- Back-to-back frames: the last stop bit ends and the next start bit begins on the same edge, with zero idle cycles.
- tx_busy falls on the edge where the FSM enters IDLE with the FIFO empty.
- tx_ready rises on the edge after a pop frees the full FIFO.

## Test plan
- Baseline frame (CLK_PER_BIT=4, 8N1): write 0xA5 once -> tx: 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 cycles. tx_busy is high for 40 cycles after the pop edge plus the acceptance cycle.
- Parity and stop-bit modes:
  - DATA_BITS=7, PARITY=1 (odd), STOP_BITS=2, write 0x03 -> 7 data bits 1100000, parity 1, two high stop bits.
  - Repeat with PARITY=2 (even) -> parity 0.
- FIFO fill and backpressure (FIFO_DEPTH=4): write 6 words on consecutive cycles.
  - First pop frees one slot, so 5 words are accepted.
  - tx_ready=0 from the cycle after the 5th acceptance; the 6th write is dropped.
  - fifo_count peaks at 4.
  - 5 frames go out contiguously with no idle cycles between frames.
- Simultaneous write and pop: time a write to the edge the STOP state pops the FIFO -> fifo_count unchanged and frame order preserved.
- Reset mid-frame:
  - Assert rst during data bit 3 with 2 words queued -> tx=1 and tx_busy=0 immediately; fifo_count=0.
  - After release, a fresh write transmits correctly.
- Width extremes: DATA_BITS=5 with word 0x1F, and DATA_BITS=9 with word 0x155, no parity -> correct bit count and values; no spurious extra bit.
